// File: rtl/axi_write_scheduler.sv
// Round-robin front end that shares one axi_write_master between C_NUM_REQ requesters.
// One command in flight at a time; the granted requester's stream is muxed into the master.
module axi_write_scheduler #(
    parameter int C_NUM_REQ          = 4,
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_DATA_WIDTH       = 32,
    parameter int C_MAX_LENGTH_WIDTH = 32,
    localparam int LP_ID_WIDTH       = $clog2(C_NUM_REQ)
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic [C_NUM_REQ-1:0]                    req_valid,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0]       req_offset,
    input  logic [C_NUM_REQ*C_MAX_LENGTH_WIDTH-1:0] req_length,
    output logic [C_NUM_REQ-1:0]                    req_ready,
    output logic [C_NUM_REQ-1:0]                    req_done,
    input  logic [C_NUM_REQ-1:0]                    s_tvalid,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0]       s_tdata,
    output logic [C_NUM_REQ-1:0]                    s_tready,
    output logic                                    m_ctrl_start,
    output logic [C_ADDR_WIDTH-1:0]                 m_ctrl_offset,
    output logic [C_MAX_LENGTH_WIDTH-1:0]           m_ctrl_length,
    input  logic                                    m_ctrl_done,
    output logic                                    m_tvalid,
    output logic [C_DATA_WIDTH-1:0]                 m_tdata,
    input  logic                                    m_tready,
    output logic                                    busy,
    output logic [LP_ID_WIDTH-1:0]                  grant_id,
    output logic [31:0]                             cmd_count
);

    typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

    state_t                          state, state_nxt;
    logic [LP_ID_WIDTH-1:0]          last_grant;
    logic [LP_ID_WIDTH-1:0]          gnt;
    logic                            gnt_found;
    logic                            take_grant;
    logic [C_MAX_LENGTH_WIDTH-1:0]   beat_cnt;
    logic                            done_seen;
    logic [C_ADDR_WIDTH-1:0]         sel_offset;
    logic [C_MAX_LENGTH_WIDTH-1:0]   sel_length;

    assign sel_offset = req_offset[gnt*C_ADDR_WIDTH +: C_ADDR_WIDTH];
    assign sel_length = req_length[gnt*C_MAX_LENGTH_WIDTH +: C_MAX_LENGTH_WIDTH];
    assign busy       = (state != IDLE);

    // Search upward from the requester after the last grant, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 1; k <= C_NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % C_NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt       = LP_ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        s_tready     = '0;
        m_tvalid     = 1'b0;
        m_tdata      = s_tdata[grant_id*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_ctrl_start = 1'b0;
        take_grant   = 1'b0;
        case (state)
            IDLE: begin
                // Holding off while req_done is up keeps the grant in the cycle after completion.
                if (gnt_found && req_done == '0) begin
                    take_grant     = 1'b1;
                    req_ready[gnt] = 1'b1;
                    if (sel_length != '0) state_nxt = START;
                end
            end
            START: begin
                m_ctrl_start = 1'b1;
                state_nxt    = STREAM;
            end
            STREAM: begin
                m_tvalid           = s_tvalid[grant_id];
                s_tready[grant_id] = m_tready;
                if (m_tvalid && m_tready && beat_cnt == C_MAX_LENGTH_WIDTH'(1))
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_ctrl_done || done_seen) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            last_grant    <= LP_ID_WIDTH'(C_NUM_REQ - 1);
            grant_id      <= '0;
            m_ctrl_offset <= '0;
            m_ctrl_length <= '0;
            beat_cnt      <= '0;
            done_seen     <= 1'b0;
            req_done      <= '0;
            cmd_count     <= '0;
        end else begin
            state    <= state_nxt;
            req_done <= '0;
            if (take_grant) begin
                grant_id      <= gnt;
                last_grant    <= gnt;
                m_ctrl_offset <= sel_offset;
                m_ctrl_length <= sel_length;
                done_seen     <= 1'b0;
                // Zero-length commands complete without ever starting the master.
                if (sel_length == '0) begin
                    req_done[gnt] <= 1'b1;
                    cmd_count     <= cmd_count + 32'd1;
                end
            end
            if (state == START)
                beat_cnt <= m_ctrl_length;
            else if (state == STREAM && m_tvalid && m_tready)
                beat_cnt <= beat_cnt - C_MAX_LENGTH_WIDTH'(1);
            // Early done from the master is remembered so WAIT_DONE exits at once.
            if (state == STREAM && m_ctrl_done)
                done_seen <= 1'b1;
            if (state == WAIT_DONE && state_nxt == IDLE) begin
                req_done[grant_id] <= 1'b1;
                cmd_count          <= cmd_count + 32'd1;
                done_seen          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_write_scheduler.sv
// Randomized bench for axi_write_scheduler; the bench plays requesters and the write master.
module tb_axi_write_scheduler;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int LW = 32;
    localparam int IW = 2;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      req_valid, req_ready, req_done, s_tvalid, s_tready;
    logic [N*AW-1:0]   req_offset;
    logic [N*LW-1:0]   req_length;
    logic [N*DW-1:0]   s_tdata;
    logic              m_ctrl_start, m_ctrl_done, m_tvalid, m_tready, busy;
    logic [AW-1:0]     m_ctrl_offset;
    logic [LW-1:0]     m_ctrl_length;
    logic [DW-1:0]     m_tdata;
    logic [IW-1:0]     grant_id;
    logic [31:0]       cmd_count;

    logic [AW-1:0]     off_a [N];
    logic [LW-1:0]     len_a [N];
    int                n_chk = 0;
    int                n_fail = 0;
    int                model_last = N - 1;
    logic [31:0]       model_count = 0;

    axi_write_scheduler #(
        .C_NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MAX_LENGTH_WIDTH(LW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_offset(req_offset), .req_length(req_length),
        .req_ready(req_ready), .req_done(req_done),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
        .m_ctrl_start(m_ctrl_start), .m_ctrl_offset(m_ctrl_offset), .m_ctrl_length(m_ctrl_length),
        .m_ctrl_done(m_ctrl_done), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready),
        .busy(busy), .grant_id(grant_id), .cmd_count(cmd_count)
    );

    always #5 aclk = ~aclk;

    always_comb begin
        req_offset = '0;
        req_length = '0;
        for (int i = 0; i < N; i++) begin
            req_offset[i*AW +: AW] = off_a[i];
            req_length[i*LW +: LW] = len_a[i];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arbiter: first pending requester after the previous winner, wrapping.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // One full command: grant, start, stream with the given master behaviour, completion.
    task automatic do_command(input bit keep, input int mode, input int done_beat, input int done_delay);
        int             g, len, beats, cyc;
        bit             hs;
        logic [N-1:0]   one;
        logic [N-1:0]   exp_v;
        logic [DW-1:0]  words[$];
        one = 1;
        #1;
        g = rr_pick(model_last, req_valid);
        if (g < 0) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_setup: no requester pending");
            return;
        end
        n_chk++; if (req_ready !== (one << g)) begin n_fail++; $display("FAIL req_ready: got %b want %b", req_ready, one << g); end
        len = int'(len_a[g]);
        words.delete();
        for (int i = 0; i < len; i++) words.push_back($urandom);
        tick;
        model_last = g;
        if (!keep) req_valid[g] = 1'b0;
        s_tvalid = '1;
        m_tready = 1'b1;
        #1;
        n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL ready_one_cycle: got %b want 0", req_ready); end
        n_chk++; if (grant_id !== IW'(g)) begin n_fail++; $display("FAIL grant_id: got %0d want %0d", grant_id, g); end
        n_chk++; if (m_ctrl_offset !== off_a[g]) begin n_fail++; $display("FAIL ctrl_offset: got %h want %h", m_ctrl_offset, off_a[g]); end
        n_chk++; if (m_ctrl_length !== len_a[g]) begin n_fail++; $display("FAIL ctrl_length: got %0d want %0d", m_ctrl_length, len_a[g]); end
        n_chk++; if (m_tvalid !== 1'b0 || s_tready !== '0) begin n_fail++; $display("FAIL no_fwd_start: got tvalid %b tready %b want 0", m_tvalid, s_tready); end
        if (len == 0) begin
            model_count++;
            n_chk++; if (req_done !== (one << g)) begin n_fail++; $display("FAIL zero_done: got %b want %b", req_done, one << g); end
            n_chk++; if (m_ctrl_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_nostart: got start %b busy %b want 0", m_ctrl_start, busy); end
            n_chk++; if (cmd_count !== model_count) begin n_fail++; $display("FAIL zero_count: got %0d want %0d", cmd_count, model_count); end
            tick;
            n_chk++; if (req_done !== '0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", req_done); end
            return;
        end
        n_chk++; if (m_ctrl_start !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL start: got start %b busy %b want 1", m_ctrl_start, busy); end
        tick;
        beats = 0;
        cyc   = 0;
        while (beats < len && cyc < 5000) begin
            if (mode == 0)      m_tready = 1'b1;
            else if (mode == 1) m_tready = (cyc % 2 == 0);
            else                m_tready = ($urandom % 2) != 0;
            s_tvalid = N'($urandom);
            if (mode == 0) s_tvalid[g] = 1'b1;
            for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = $urandom;
            s_tdata[g*DW +: DW] = words[beats];
            hs = m_tready && s_tvalid[g];
            m_ctrl_done = (done_beat > 0 && hs && beats + 1 == done_beat);
            exp_v = m_tready ? (one << g) : '0;
            #1;
            n_chk++; if (m_tvalid !== s_tvalid[g]) begin n_fail++; $display("FAIL fwd_tvalid: got %b want %b beat %0d", m_tvalid, s_tvalid[g], beats); end
            n_chk++; if (s_tready !== exp_v) begin n_fail++; $display("FAIL fwd_tready: got %b want %b beat %0d", s_tready, exp_v, beats); end
            n_chk++; if (m_ctrl_start !== 1'b0) begin n_fail++; $display("FAIL start_overlap: got %b want 0", m_ctrl_start); end
            if (hs) begin
                n_chk++; if (m_tdata !== words[beats]) begin n_fail++; $display("FAIL fwd_data: got %h want %h beat %0d", m_tdata, words[beats], beats); end
            end
            tick;
            m_ctrl_done = 1'b0;
            if (hs) beats++;
            cyc++;
        end
        if (beats < len) begin
            n_chk++; n_fail++;
            $display("FAIL stream_timeout: got %0d beats want %0d", beats, len);
        end
        s_tvalid = '1;
        m_tready = 1'b1;
        #1;
        n_chk++; if (m_tvalid !== 1'b0 || s_tready !== '0) begin n_fail++; $display("FAIL excess_beat: got tvalid %b tready %b want 0", m_tvalid, s_tready); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b want 1", busy); end
        if (done_beat == 0) begin
            repeat (done_delay) begin
                tick;
                n_chk++; if (req_done !== '0) begin n_fail++; $display("FAIL early_done: got %b want 0", req_done); end
            end
            m_ctrl_done = 1'b1;
            tick;
            m_ctrl_done = 1'b0;
        end else begin
            tick;
        end
        #1;
        model_count++;
        n_chk++; if (req_done !== (one << g)) begin n_fail++; $display("FAIL req_done: got %b want %b", req_done, one << g); end
        n_chk++; if (cmd_count !== model_count) begin n_fail++; $display("FAIL cmd_count: got %0d want %0d", cmd_count, model_count); end
        n_chk++; if (busy !== 1'b0 || req_ready !== '0) begin n_fail++; $display("FAIL done_idle: got busy %b ready %b want 0", busy, req_ready); end
        n_chk++; if (m_ctrl_offset !== off_a[g] || m_ctrl_length !== len_a[g]) begin n_fail++; $display("FAIL ctrl_hold: got %h/%0d want %h/%0d", m_ctrl_offset, m_ctrl_length, off_a[g], len_a[g]); end
        tick;
        n_chk++; if (req_done !== '0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", req_done); end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) tick;
        n_chk++; if (busy !== 1'b0 || m_ctrl_start !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got busy %b start %b want 0", busy, m_ctrl_start); end
        n_chk++; if (req_ready !== '0 || req_done !== '0) begin n_fail++; $display("FAIL rst_req: got ready %b done %b want 0", req_ready, req_done); end
        n_chk++; if (m_ctrl_offset !== '0 || m_ctrl_length !== '0) begin n_fail++; $display("FAIL rst_ctrl: got %h/%0d want 0", m_ctrl_offset, m_ctrl_length); end
        n_chk++; if (grant_id !== '0 || cmd_count !== '0) begin n_fail++; $display("FAIL rst_cnt: got id %0d count %0d want 0", grant_id, cmd_count); end
        aresetn = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < N; i++) begin
            off_a[i] = {$urandom, $urandom};
            len_a[i] = 8;
        end
        req_valid = '1;
        repeat (5) do_command(1'b1, 0, 0, 2);
        req_valid = '0;
    endtask

    task automatic test_single;
        off_a[1]  = 64'h1000;
        len_a[1]  = 300;
        req_valid = 4'b0010;
        do_command(1'b0, 0, 0, 3);
    endtask

    task automatic test_zero_length;
        off_a[2]  = {$urandom, $urandom};
        len_a[2]  = 0;
        req_valid = 4'b0100;
        do_command(1'b0, 0, 0, 0);
    endtask

    task automatic test_backpressure;
        off_a[1]  = {$urandom, $urandom};
        len_a[1]  = 17;
        req_valid = 4'b0010;
        do_command(1'b0, 1, 0, 1);
    endtask

    task automatic test_done_in_stream;
        off_a[3]  = {$urandom, $urandom};
        len_a[3]  = 4;
        req_valid = 4'b1000;
        do_command(1'b0, 0, 3, 0);
    endtask

    task automatic test_random;
        logic [N-1:0] nv;
        int           db;
        for (int t = 0; t < 12; t++) begin
            nv = N'($urandom);
            if (nv == '0 && req_valid == '0) nv[$urandom % N] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (nv[i] && !req_valid[i]) begin
                    off_a[i]     = {$urandom, $urandom};
                    len_a[i]     = $urandom % 11;
                    req_valid[i] = 1'b1;
                end
            end
            db = 0;
            if ($urandom % 3 == 0) begin
                int gp;
                gp = rr_pick(model_last, req_valid);
                if (len_a[gp] != 0) db = 1 + int'($urandom % len_a[gp]);
            end
            do_command(1'b0, 2, db, int'($urandom % 4));
        end
        for (int k = 0; k < N && req_valid != '0; k++) do_command(1'b0, 2, 0, 1);
    endtask

    task automatic test_reset_mid_stream;
        logic [N-1:0] one;
        one       = 1;
        off_a[2]  = 64'h2000;
        len_a[2]  = 20;
        req_valid = 4'b0100;
        m_tready  = 1'b1;
        s_tvalid  = '0;
        #1;
        n_chk++; if (req_ready !== (one << rr_pick(model_last, req_valid))) begin n_fail++; $display("FAIL mid_ready: got %b want %b", req_ready, one << 2); end
        tick;
        req_valid = '0;
        tick;
        s_tvalid = '1;
        repeat (5) tick;
        aresetn = 1'b0;
        tick;
        model_count = 0;
        model_last  = N - 1;
        n_chk++; if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== '0) begin n_fail++; $display("FAIL mid_rst_state: got busy %b tvalid %b tready %b want 0", busy, m_tvalid, s_tready); end
        n_chk++; if (req_done !== '0 || m_ctrl_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got done %b start %b want 0", req_done, m_ctrl_start); end
        n_chk++; if (grant_id !== '0 || m_ctrl_offset !== '0 || m_ctrl_length !== '0) begin n_fail++; $display("FAIL mid_rst_ctrl: got %0d %h %0d want 0", grant_id, m_ctrl_offset, m_ctrl_length); end
        n_chk++; if (cmd_count !== model_count) begin n_fail++; $display("FAIL mid_rst_count: got %0d want %0d", cmd_count, model_count); end
        aresetn  = 1'b1;
        s_tvalid = '0;
        tick;
        n_chk++; if (req_done !== '0) begin n_fail++; $display("FAIL mid_no_done: got %b want 0", req_done); end
        off_a[0]  = {$urandom, $urandom};
        len_a[0]  = 3;
        off_a[3]  = {$urandom, $urandom};
        len_a[3]  = 2;
        req_valid = 4'b1001;
        do_command(1'b0, 0, 0, 1);
        do_command(1'b0, 0, 0, 1);
    endtask

    initial begin
        aresetn     = 1'b0;
        req_valid   = '0;
        s_tvalid    = '0;
        s_tdata     = '0;
        m_tready    = 1'b0;
        m_ctrl_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            off_a[i] = '0;
            len_a[i] = '0;
        end
        test_reset;
        test_round_robin;
        test_single;
        test_zero_length;
        test_backpressure;
        test_done_in_stream;
        test_random;
        test_reset_mid_stream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_write_scheduler.md
Name: axi_write_scheduler

Overview:
- Shares one axi_write_master between C_NUM_REQ requesters, each supplying write commands (offset, length) plus a data stream.
- Arbitrates round-robin, drives the master's ctrl_start/offset/length, and routes the granted requester's stream into the master.
- Waits for ctrl_done before granting again, so exactly one command is in flight at a time.
- Sits directly in front of axi_write_master, in the same clock domain.

Parameters:
- C_NUM_REQ, 4, number of requesters; must be >= 2.
- C_ADDR_WIDTH, 64, byte address width.
- C_DATA_WIDTH, 32, stream/AXI data width.
- C_MAX_LENGTH_WIDTH, 32, command length width, in beats.
- LP_ID_WIDTH (localparam), $clog2(C_NUM_REQ), grant index width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- req_valid  in  C_NUM_REQ  per-requester command pending.
- req_offset  in  C_NUM_REQ*C_ADDR_WIDTH  packed byte offsets; requester i at [i*C_ADDR_WIDTH +: C_ADDR_WIDTH].
- req_length  in  C_NUM_REQ*C_MAX_LENGTH_WIDTH  packed beat counts.
- req_ready  out  C_NUM_REQ  one-hot acceptance pulse.
- req_done  out  C_NUM_REQ  one-hot completion pulse.
- s_tvalid  in  C_NUM_REQ  per-requester stream valid.
- s_tdata  in  C_NUM_REQ*C_DATA_WIDTH  packed stream data.
- s_tready  out  C_NUM_REQ  per-requester stream ready.
- m_ctrl_start  out  1  to master ctrl_start.
- m_ctrl_offset  out  C_ADDR_WIDTH  to master ctrl_offset.
- m_ctrl_length  out  C_MAX_LENGTH_WIDTH  to master ctrl_length.
- m_ctrl_done  in  1  from master ctrl_done.
- m_tvalid  out  1  to master s_tvalid.
- m_tdata  out  C_DATA_WIDTH  to master s_tdata.
- m_tready  in  1  from master s_tready.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  LP_ID_WIDTH  index of current or last granted requester.
- cmd_count  out  32  completed-command counter; wraps at 2^32.

Behaviour:
- Reset (aresetn=0 at clock edge), all outputs as follows:
  - state=IDLE.
  - req_ready, req_done, m_ctrl_start, busy = 0.
  - m_ctrl_offset, m_ctrl_length, grant_id = 0; cmd_count = 0.
  - Round-robin pointer last_grant = C_NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-command abandons it without a req_done. The master must share the same reset.
- State machine (IDLE, START, STREAM, WAIT_DONE):
  - IDLE:
    - If any req_valid, grant g = first set index searching upward from last_grant+1, modulo C_NUM_REQ.
    - In the same cycle, req_ready[g]=1 (combinational, one cycle only).
    - Register offset/length into m_ctrl_offset/m_ctrl_length; grant_id<=g; last_grant<=g.
    - If the length is nonzero, go to START.
    - If the length is 0, pulse req_done[g] and increment cmd_count next cycle, stay IDLE. The master is never started for length 0.
  - START: m_ctrl_start=1 for exactly this one cycle. Next state STREAM. No data forwarded in this cycle.
  - STREAM:
    - Forwarding mux: m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], s_tready[g]=m_tready. s_tready for all other requesters = 0.
    - Beat counter (C_MAX_LENGTH_WIDTH bits) loads length in START and decrements on m_tvalid&m_tready.
    - On the beat that takes the counter to 0, go to WAIT_DONE. After that beat, m_tvalid=0 and s_tready[g]=0, so no excess beats pass.
  - WAIT_DONE: on m_ctrl_done=1, pulse req_done[g] the following cycle, increment cmd_count, return to IDLE.
- Outside STREAM: m_tvalid=0, all s_tready=0.
- m_ctrl_offset/m_ctrl_length hold stable from the grant until the next grant (the master samples length continuously).
- m_ctrl_done arriving in STREAM (protocol violation tolerance) is latched into done_seen; WAIT_DONE then completes immediately.
- A new grant is possible in the cycle after req_done (back-to-back). Minimum command period: 4 cycles plus beats plus master latency.
- Requests arriving while busy are held off (req_ready=0); req_valid must stay asserted until req_ready.
- An unused requester with req_valid=0 never blocks others.

Test Plan:
- Single request: requester 1, offset 0x1000, length 300, continuous data, m_tready=1.
  - req_ready[1] one cycle.
  - m_ctrl_start one cycle later, offset 0x1000, length 300.
  - Exactly 300 beats forwarded; s_tready[1]=0 after beat 300.
  - req_done[1] one cycle after m_ctrl_done; cmd_count=1.
- All four req_valid held high, each length 8:
  - Grant order 0,1,2,3,0.
  - grant_id matches each grant; no overlapping m_ctrl_start.
- Zero-length request on requester 2:
  - req_ready[2] then req_done[2] the next cycle.
  - m_ctrl_start never asserted; cmd_count +1.
- Backpressure: m_tready toggled every other cycle, length 17:
  - 17 beats, data order preserved.
  - Non-granted s_tready stay 0 throughout.
- Reset mid-STREAM after 5 of 20 beats:
  - All outputs return to reset values next cycle; no req_done.
  - Next grant goes to requester 0 if its req_valid is set.
- m_ctrl_done injected during STREAM at beat 3 of 4:
  - After beat 4, req_done fires within 2 cycles; state returns to IDLE.
